genius_playback_sched: RTL and testbench
========================================

// Module: genius_playback_sched
// PURPOSE
//  Sequencer for the Genius LED playback: when the game controller enters its show-sequence step, this block
//  reads the stored colour sequence from the datapath's synchronous sequence memory and lights one LED per
//  step for a timed on/off cadence. It then pulses done, which drives end_FPGA into the controller.
//  Sits between the controller (start/done) and the datapath (sequence memory read port, LEDR[9:6]).
// PARAMETERS
//  SEQ_LEN_MAX  16          maximum sequence length (steps)
//  IDX_W        4           sequence index width, clog2(SEQ_LEN_MAX)
//  ON_TICKS     25000000    LED-on time in CLOCK cycles at speed 0 (0.5 s at 50 MHz)
//  OFF_TICKS    12500000    inter-step dark gap in CLOCK cycles at speed 0
//  CNT_W        25          timer width; must hold max(ON_TICKS,OFF_TICKS)
// PORTS
//  CLOCK    in   1        system clock (50 MHz)
//  reset    in   1        synchronous, active-high reset
//  start    in   1        begin playback; sampled only in IDLE
//  round    in   IDX_W+1  number of steps to play; 0 means none; values above SEQ_LEN_MAX are clamped
//  speed    in   2        level; on/off durations are shifted right by speed
//  rd_addr  out  IDX_W    sequence memory address
//  rd_data  in   2        colour code returned 1 cycle after rd_addr
//  leds     out  4        one-hot colour LEDs (LEDR[9:6]); leds[rd_data]=1 while lit
//  busy     out  1        high from the cycle after start is accepted until done
//  done     out  1        one-cycle pulse at end of playback (end_FPGA)
// BEHAVIOUR
//  Reset: state=IDLE; idx=0; rd_addr=0; leds=0; busy=0; done=0; timer=0. Takes priority over every other input.
//  Only start and round have an effect in IDLE; round is latched (after clamping) when start is accepted.
//  States and transitions:
//   - IDLE: if start: if round==0, go to DONE; otherwise go to FETCH with idx=0.
//   - FETCH (1 cycle): rd_addr=idx; go to ON.
//   - ON: leds=onehot(rd_data), registered on ON entry; timer loaded with max(ON_TICKS>>speed,1)-1.
//     Stay until timer==0, then go to OFF.
//   - OFF: leds=0; timer loaded with max(OFF_TICKS>>speed,1)-1. When timer==0: go to DONE if idx==round_q-1,
//     else increment idx and go to FETCH.
//   - DONE (1 cycle): done=1, busy=0; go to IDLE.
//  speed is sampled at each timer load, so a change takes effect from the next phase.
//  Latency: start high in cycle t -> FETCH at t+1 -> leds valid at t+2.
//  Each LED is lit exactly max(ON_TICKS>>speed,1) cycles and each gap is exactly max(OFF_TICKS>>speed,1)
//  cycles; the FETCH cycle is additional and is also dark.
//  Boundaries:
//   - start while busy: ignored; round/speed changes mid-play do not alter round_q.
//   - round==0: done pulses at t+1 and leds never light.
//   - idx never wraps: terminates at round_q-1 <= SEQ_LEN_MAX-1.
//   - reset mid-playback: returns to IDLE with leds=0 the next cycle and no done pulse.
//   - start and reset in the same cycle: reset wins.
// CONFIGURATION
//  `define PLAYBACK_ABORT_EN adds input abort (1 bit).
//   - abort high in any non-IDLE state -> next cycle IDLE, leds=0, busy=0, no done pulse.
//   - abort in IDLE is ignored; abort has lower priority than reset.
//  Without PLAYBACK_ABORT_EN the port does not exist and playback always runs to DONE.
// STRUCTURE
//  genius_pkg holds: state encoding localparams (IDLE, FETCH, ON, OFF, DONE), colour codes
//  (GREEN=0, RED=1, YELLOW=2, BLUE=3), the onehot LED table, and default ON_TICKS/OFF_TICKS.
//  Sub-module tick_timer (load, value, expire) holds the down-counter; the FSM, index and clamp logic are top-level.
// TESTING  (bench params: ON_TICKS=4, OFF_TICKS=2, SEQ_LEN_MAX=16; memory model = 1-cycle ROM {2,0,3,1,...})
//  1 round=3, speed=0, start pulse -> leds 0100 x4, 0000 x3, 0001 x4, 0000 x3, 1000 x4, 0000 x2; done 1 cycle; busy low after.
//  2 round=0, start -> done=1 at t+1, leds stay 0000, busy never high.
//  3 round=31 -> clamped to 16: exactly 16 lit phases, rd_addr sequence 0..15, then done.
//  4 speed=2, round=1 -> lit 1 cycle (4>>2), dark max(2>>2,1)=1 cycle, then done.
//  5 reset asserted during 2nd ON phase -> next cycle leds=0, busy=0, no done; new start replays from idx 0.
//  6 start re-pulsed while busy -> no restart, total timing identical to scenario 1.
//    With PLAYBACK_ABORT_EN: abort in OFF -> IDLE next cycle, no done.

Source files
------------

// File: rtl/genius_pkg.sv
// genius_pkg: shared definitions for the Genius LED playback sequencer.
//   - FSM state encodings (IDLE, FETCH, ON, OFF, DONE)
//   - colour codes as stored in the sequence memory
//   - colour -> one-hot LED lookup table (LEDR[9:6])
//   - default on/off phase lengths for a 50 MHz CLOCK
package genius_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] ON    = 3'd2;
    localparam logic [2:0] OFF   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] GREEN  = 2'd0;
    localparam logic [1:0] RED    = 2'd1;
    localparam logic [1:0] YELLOW = 2'd2;
    localparam logic [1:0] BLUE   = 2'd3;

    // Element [c] is the LED pattern for colour code c.
    localparam logic [3:0][3:0] LED_TABLE = {
        4'b0001 << BLUE,
        4'b0001 << YELLOW,
        4'b0001 << RED,
        4'b0001 << GREEN
    };

    localparam int unsigned DEF_ON_TICKS  = 25000000;
    localparam int unsigned DEF_OFF_TICKS = 12500000;

endpackage

// File: rtl/genius_playback_sched_tick_timer.sv
// tick_timer: loadable down-counter for the playback phase timing.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset (count -> 0)
//   load    in   load value into the counter this cycle
//   value   in   CNT_W  count to load (phase length minus one)
//   expire  out  counter is at zero
module tick_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/genius_playback_sched.sv
// genius_playback_sched: plays the stored Genius colour sequence on LEDR[9:6].
// On start (in IDLE) it walks round (clamped to SEQ_LEN_MAX) entries of the
// synchronous sequence memory, lighting one LED per step for an on phase
// followed by a dark gap, then pulses done (end_FPGA).
// Ports:
//   CLOCK    in   system clock
//   reset    in   synchronous active-high reset
//   start    in   begin playback (IDLE only)
//   round    in   IDX_W+1  steps to play, 0 = none, clamped to SEQ_LEN_MAX
//   speed    in   2        phase lengths are shifted right by speed
//   rd_addr  out  IDX_W    sequence memory address
//   rd_data  in   2        colour code, one cycle after rd_addr
//   leds     out  4        one-hot colour LEDs
//   busy     out  1        playback in progress
//   done     out  1        one-cycle end-of-playback pulse
//   abort    in   1        (only with `define PLAYBACK_ABORT_EN) cancel playback
import genius_pkg::*;

module genius_playback_sched #(
    parameter int unsigned SEQ_LEN_MAX = 16,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned ON_TICKS    = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS   = DEF_OFF_TICKS,
    parameter int unsigned CNT_W       = 25
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W:0]   round,
    input  logic [1:0]       speed,
    output logic [IDX_W-1:0] rd_addr,
    input  logic [1:0]       rd_data,
    output logic [3:0]       leds,
    output logic             busy,
    output logic             done
`ifdef PLAYBACK_ABORT_EN
    ,
    input  logic             abort
`endif
);

    logic [2:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   round_q;
    logic [IDX_W:0]   round_clamped;
    logic             last_step;
    logic             abort_hit;
    logic [CNT_W-1:0] on_shift, off_shift, on_len, off_len;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_expire;

`ifdef PLAYBACK_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        round_clamped = (round > (IDX_W+1)'(SEQ_LEN_MAX)) ? (IDX_W+1)'(SEQ_LEN_MAX) : round;
        last_step     = ({1'b0, idx} == round_q - (IDX_W+1)'(1));

        // Phase lengths follow the current speed; never shorter than one cycle.
        on_shift  = CNT_W'(ON_TICKS >> speed);
        off_shift = CNT_W'(OFF_TICKS >> speed);
        on_len    = (on_shift == '0) ? CNT_W'(1) : on_shift;
        off_len   = (off_shift == '0) ? CNT_W'(1) : off_shift;

        // Load on ON entry (from FETCH) and on OFF entry (ON expiring).
        timer_load  = (state == FETCH) || ((state == ON) && timer_expire);
        timer_value = (state == FETCH) ? (on_len - CNT_W'(1)) : (off_len - CNT_W'(1));

        busy = (state == FETCH) || (state == ON) || (state == OFF);
        done = (state == DONE);
    end

    tick_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (CLOCK),
        .reset  (reset),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

    // rd_addr runs one step ahead of idx: it moves to the next entry on OFF
    // entry so the memory output is already valid during FETCH, which lets
    // leds register straight from rd_data on ON entry.
    always_ff @(posedge CLOCK) begin
        if (reset || abort_hit) begin
            state   <= IDLE;
            idx     <= '0;
            rd_addr <= '0;
            leds    <= '0;
            if (reset) begin
                round_q <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        round_q <= round_clamped;
                        idx     <= '0;
                        state   <= (round_clamped == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    leds  <= LED_TABLE[rd_data];
                    state <= ON;
                end
                ON: begin
                    if (timer_expire) begin
                        leds    <= '0;
                        rd_addr <= last_step ? '0 : idx + IDX_W'(1);
                        state   <= OFF;
                    end
                end
                OFF: begin
                    if (timer_expire) begin
                        if (last_step) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_playback_sched.sv
module tb_genius_playback_sched;

    logic       CLOCK = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] round;
    logic [1:0] speed;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic [3:0] leds;
    logic       busy;
    logic       done;
`ifdef PLAYBACK_ABORT_EN
    logic       abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int lit;

    logic [1:0] rom [16];

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) rd_data <= rom[rd_addr];

    genius_playback_sched #(
        .SEQ_LEN_MAX (16),
        .IDX_W       (4),
        .ON_TICKS    (4),
        .OFF_TICKS   (2),
        .CNT_W       (25)
    ) dut (
        .CLOCK   (CLOCK),
        .reset   (reset),
        .start   (start),
        .round   (round),
        .speed   (speed),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .leds    (leds),
        .busy    (busy),
        .done    (done)
`ifdef PLAYBACK_ABORT_EN
        ,
        .abort   (abort)
`endif
    );

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected leds/busy/done for round=3, speed=0, c cycles after start.
    function automatic logic [3:0] exp3_leds(input int c);
        if (c >= 2 && c <= 5)   return 4'b0100;
        if (c >= 9 && c <= 12)  return 4'b0001;
        if (c >= 16 && c <= 19) return 4'b1000;
        return 4'b0000;
    endfunction

    task automatic play3(input bit repulse);
        round = 5'd3;
        speed = 2'd0;
        start = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            tick();
            start = repulse && (c == 3 || c == 10 || c == 17);
            if (repulse && c == 4) round = 5'd1;
            check($sformatf("p3 leds c%0d", c), leds, exp3_leds(c));
            check($sformatf("p3 busy c%0d", c), busy, (c >= 1 && c <= 21));
            check($sformatf("p3 done c%0d", c), done, (c == 22));
            if (c == 1)  check("p3 addr0", rd_addr, 0);
            if (c == 8)  check("p3 addr1", rd_addr, 1);
            if (c == 15) check("p3 addr2", rd_addr, 2);
        end
        round = 5'd0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: rom[i] = 2'd2;
                1: rom[i] = 2'd0;
                2: rom[i] = 2'd3;
                default: rom[i] = 2'd1;
            endcase
        end

        // Reset, with start asserted at the same time: reset wins.
        reset = 1'b1; start = 1'b1; round = 5'd3; speed = 2'd0;
        tick();
        tick();
        check("rst leds", leds, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst addr", rd_addr, 0);
        reset = 1'b0; start = 1'b0; round = 5'd0;
        tick();
        check("post-rst busy", busy, 0);

        // 1: basic three-step playback
        play3(1'b0);

        // 2: round == 0
        round = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("r0 done", done, 1);
        check("r0 busy", busy, 0);
        check("r0 leds", leds, 0);
        tick();
        check("r0 done off", done, 0);
        check("r0 busy off", busy, 0);
        check("r0 leds off", leds, 0);

        // 3: round 31 clamps to 16 steps
        round = 5'd31; start = 1'b1; lit = 0;
        for (int c = 1; c <= 114; c++) begin
            logic [3:0] prev;
            prev = leds;
            tick();
            start = 1'b0;
            if (leds != 0 && prev == 0) lit++;
            if (c % 7 == 1 && c <= 106) check($sformatf("clamp addr c%0d", c), rd_addr, (c - 1) / 7);
            if (c % 7 == 2 && c <= 107) check($sformatf("clamp leds c%0d", c), leds, 4'b0001 << rom[(c - 2) / 7]);
            if (c == 112) check("clamp done early", done, 0);
            if (c == 113) check("clamp done", done, 1);
            if (c == 114) check("clamp busy end", busy, 0);
        end
        check("clamp lit phases", lit, 16);

        // 4: speed 2, one step
        round = 5'd1; speed = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        check("spd fetch leds", leds, 0);
        tick();
        check("spd lit", leds, 4'b0100);
        tick();
        check("spd gap leds", leds, 0);
        check("spd gap busy", busy, 1);
        tick();
        check("spd done", done, 1);
        tick();
        check("spd idle", done, 0);
        speed = 2'd0;

        // 5: reset during second ON phase, then replay from idx 0
        round = 5'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        check("mid lit", leds, 4'b0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid rst leds", leds, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("mid rst addr", rd_addr, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid no done", done, 0);
        end
        play3(1'b0);

        // 6: start re-pulsed while busy, round changed mid-play
        play3(1'b1);

`ifdef PLAYBACK_ABORT_EN
        // abort during OFF
        round = 5'd3; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            start = 1'b0;
        end
        check("ab off busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab leds", leds, 0);
        check("ab busy", busy, 0);
        check("ab done", done, 0);
        tick();
        check("ab no done", done, 0);
        check("ab idle busy", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
